intmul_pipe_nxm: RTL and testbench
==================================

Name: intmul_pipe_nxm

Overview:
- Parametrised, fully pipelined integer multiplier and the generalised successor of the fixed 60x60 non-standard multiplier.
- Operand widths are arbitrary. Operands split into DSP-sized tiles; partial products reduced by optional CSA tree, then final carry-propagate add.
- Adds per-operation signed/unsigned mode, valid/tag sideband, and global stall enable.
- Feeds modular-reduction datapaths that need in-order results with a known, fixed latency.

Parameters:
- LOGA, 60, width of operand A.
- LOGB, 60, width of operand B.
- TAGW, 4, width of sideband tag carried alongside each operation.
- FF_IN, 1, register operands/mode/tag at input (0/1).
- FF_MUL, 1, register tile partial products (0/1).
- USE_CSA, 1, 1: CSA reduction tree; 0: plain adder tree.
- FF_CSA, 1, register CSA sum/carry vectors; ignored when USE_CSA=0.
- FF_OUT, 1, register final product (0/1).
- SMLL_DSP, 1, tile size: 1 gives 17x17 unsigned tiles; 0 gives 24x17 tiles (A tiled by 24).
- LAT, localparam, FF_IN+FF_MUL+(USE_CSA?FF_CSA:0)+FF_OUT, range 0..4. Must be hierarchically readable by benches.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-low reset, sampled on rising clk.
- en, input, 1, pipeline advance. When 0, all pipeline registers hold.
- in_valid, input, 1, operation present on A/B this cycle.
- sgn, input, 1, 1: A and B are two's complement; 0: unsigned.
- tag, input, TAGW, user sideband, returned with the result.
- A, input, LOGA, operand A.
- B, input, LOGB, operand B.
- out_valid, output, 1, C/out_tag hold a valid result.
- out_tag, output, TAGW, tag of the result on C.
- C, output, LOGA+LOGB, product A*B, full width, no truncation.

Behaviour:
- Reset: when rst=0 at a clk edge, every pipeline valid bit, out_valid, C and out_tag clear to 0 at that edge.
  - Reset overrides en.
  - In-flight operations are discarded; none emerge after reset releases.
  - Data registers other than the output stage may also clear, or may be left undefined, provided their valid bit is 0.
- Pipeline:
  - Each stage carries {valid, sgn, tag, data}.
  - With en=1 at every edge, an op accepted at edge k appears on C/out_valid/out_tag immediately after edge k+LAT-1 (stable before edge k+LAT). This is the same "apply, wait LAT clocks, sample" timing the existing multiplier benches use.
  - Throughput is one op per cycle. Ordering is strict FIFO.
- LAT=0: fully combinational. out_valid=in_valid, out_tag=tag, C=f(A,B,sgn) in the same cycle. rst has no effect in this configuration.
- Stall: en=0 freezes all stages, including outputs. in_valid is ignored while en=0; the producer must hold or re-present the op.
- Invalid slots propagate as bubbles. C content with out_valid=0 is don't-care, except after reset, where it is 0.
- Arithmetic:
  - Unsigned: C = A*B exactly.
  - Signed: A and B sign-extended by one bit internally; C is the two's-complement product mod 2^(LOGA+LOGB). Exact, since |product| fits.
  - Tile decomposition:
    - Tiles are unsigned; the top tile is zero-padded.
    - Signed correction is via a sign-extension term or Baugh-Wooley. Any method is acceptable if bit-exact.
    - The final adder output is truncated to LOGA+LOGB bits.
- sgn and tag travel with their op; mode may change every cycle.
- Widths: any LOGA, LOGB in 2..128 must elaborate. Tile count is ceil(LOGA/TA)*ceil(LOGB/TB).

Test Plan:
- Default config, unsigned, A=B=2^60-1, then zeros.
  - Expected: after LAT cycles C=0xFFFFFFFFFFFFFFE000000000000001 with out_valid=1.
  - Expected: next cycle C=0.
- Signed cases:
  - A=all-ones (-1), B=2, sgn=1 → C=2^120-2 (all ones except bit0), out_valid=1.
  - A=-1, B=-1, sgn=1 → C=1.
  - Same A=B=all-ones with sgn=0 → unsigned max product.
- Throughput: 16 back-to-back ops, random A/B/sgn, tag=0..15, en=1.
  - Expected: 16 consecutive out_valid cycles starting LAT cycles after the first op.
  - Expected: out_tag 0..15 in order, each C matching the reference model.
- Stall and bubbles: issue 4 ops with in_valid gaps, drop en for 3 cycles mid-flight.
  - Expected: outputs frozen during the stall.
  - Expected: results emerge in order, count exactly 4, each delayed by 3 cycles.
- Reset mid-flight: 3 ops in flight, rst=0 for one edge, then idle.
  - Expected: out_valid=0, C=0, out_tag=0 after that edge.
  - Expected: no valid output for 2*LAT cycles afterwards.
- Config sweep over each combination:
  - Configs: LOGA/LOGB in {17x17, 60x60, 64x33}; FF_* all-0 (LAT=0) and all-1 (LAT=4); USE_CSA in {0,1}; SMLL_DSP in {0,1}.
  - Stimulus: 1000 random signed and unsigned ops.
  - Expected: bit-exact against the reference model, with latency equal to LAT.

Source files
------------

// File: rtl/intmul_pipe_nxm.sv
// Tiled N x M integer multiplier with per-op signed/unsigned mode.
// Optional registers at input, partial products, CSA vectors and output.
module intmul_pipe_nxm #(
    parameter int LOGA     = 60,
    parameter int LOGB     = 60,
    parameter int TAGW     = 4,
    parameter int FF_IN    = 1,
    parameter int FF_MUL   = 1,
    parameter int USE_CSA  = 1,
    parameter int FF_CSA   = 1,
    parameter int FF_OUT   = 1,
    parameter int SMLL_DSP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic                 sgn,
    input  logic [TAGW-1:0]      tag,
    input  logic [LOGA-1:0]      A,
    input  logic [LOGB-1:0]      B,
    output logic                 out_valid,
    output logic [TAGW-1:0]      out_tag,
    output logic [LOGA+LOGB-1:0] C
);
    localparam int LAT  = FF_IN + FF_MUL + ((USE_CSA != 0) ? FF_CSA : 0) + FF_OUT;
    localparam int W    = LOGA + LOGB;
    localparam int TA   = (SMLL_DSP != 0) ? 17 : 24;
    localparam int TB   = 17;
    localparam int NA   = (LOGA + TA - 1) / TA;
    localparam int NB   = (LOGB + TB - 1) / TB;
    localparam int NT   = NA * NB;
    localparam int NROW = NT + 1;
    localparam int PA   = NA * TA;
    localparam int PB   = NB * TB;

    logic            v0, s0;
    logic [TAGW-1:0] t0;
    logic [LOGA-1:0] a0;
    logic [LOGB-1:0] b0;

    generate
        if (FF_IN != 0) begin : g_in
            logic            v_q, s_q;
            logic [TAGW-1:0] t_q;
            logic [LOGA-1:0] a_q;
            logic [LOGB-1:0] b_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    v_q <= 1'b0;
                    s_q <= 1'b0;
                    t_q <= '0;
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    v_q <= in_valid;
                    s_q <= sgn;
                    t_q <= tag;
                    a_q <= A;
                    b_q <= B;
                end
            end
            assign v0 = v_q;
            assign s0 = s_q;
            assign t0 = t_q;
            assign a0 = a_q;
            assign b0 = b_q;
        end else begin : g_in_c
            assign v0 = in_valid;
            assign s0 = sgn;
            assign t0 = tag;
            assign a0 = A;
            assign b0 = B;
        end
    endgenerate

    // Last row folds in the signed correction: -(msbA*B<<LOGA) - (msbB*A<<LOGB).
    logic [W-1:0] pp_d [NROW];

    always_comb begin : mul
        logic [PA-1:0]    pa;
        logic [PB-1:0]    pb;
        logic [TA+TB-1:0] p;
        logic [W-1:0]     ca, cb;
        for (int k = 0; k < NROW; k++) pp_d[k] = '0;
        pa = PA'(a0);
        pb = PB'(b0);
        p  = '0;
        for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NB; j++) begin
                p = (TA+TB)'(pa[i*TA +: TA]) * (TA+TB)'(pb[j*TB +: TB]);
                pp_d[i*NB+j] = W'(p) << (i*TA + j*TB);
            end
        end
        ca = '0;
        cb = '0;
        if (s0 && a0[LOGA-1]) ca = W'(b0) << LOGA;
        if (s0 && b0[LOGB-1]) cb = W'(a0) << LOGB;
        pp_d[NT] = -(ca + cb);
    end

    logic            v1;
    logic [TAGW-1:0] t1;
    logic [W-1:0]    pp1 [NROW];

    generate
        if (FF_MUL != 0) begin : g_mul
            logic            v_q;
            logic [TAGW-1:0] t_q;
            logic [W-1:0]    pp_q [NROW];
            always_ff @(posedge clk) begin
                if (!rst) begin
                    v_q <= 1'b0;
                    t_q <= '0;
                    for (int k = 0; k < NROW; k++) pp_q[k] <= '0;
                end else if (en) begin
                    v_q <= v0;
                    t_q <= t0;
                    pp_q <= pp_d;
                end
            end
            assign v1  = v_q;
            assign t1  = t_q;
            assign pp1 = pp_q;
        end else begin : g_mul_c
            assign v1  = v0;
            assign t1  = t0;
            assign pp1 = pp_d;
        end
    endgenerate

    logic [W-1:0] sum_d, cry_d;

    generate
        if (USE_CSA != 0) begin : g_csa
            always_comb begin : tree
                logic [W-1:0] t [NROW];
                logic [W-1:0] u [NROW];
                logic [W-1:0] maj;
                int           n, m;
                t   = pp1;
                n   = NROW;
                m   = 0;
                maj = '0;
                for (int k = 0; k < NROW; k++) u[k] = '0;
                for (int l = 0; l < NROW; l++) begin
                    if (n > 2) begin
                        m = 0;
                        for (int k = 0; k < NROW; k++) u[k] = '0;
                        for (int i = 0; i < NROW; i += 3) begin
                            if (i + 2 < n) begin
                                maj = (t[i] & t[i+1]) | (t[i] & t[i+2])
                                    | (t[i+1] & t[i+2]);
                                u[m]   = t[i] ^ t[i+1] ^ t[i+2];
                                u[m+1] = maj << 1;
                                m = m + 2;
                            end else if (i < n) begin
                                u[m] = t[i];
                                m = m + 1;
                                if (i + 1 < n) begin
                                    u[m] = t[i+1];
                                    m = m + 1;
                                end
                            end
                        end
                        t = u;
                        n = m;
                    end
                end
                sum_d = t[0];
                cry_d = (n > 1) ? t[1] : '0;
            end
        end else begin : g_add
            always_comb begin : addt
                sum_d = '0;
                for (int i = 0; i < NROW; i++) sum_d = sum_d + pp1[i];
                cry_d = '0;
            end
        end
    endgenerate

    logic            v2;
    logic [TAGW-1:0] t2;
    logic [W-1:0]    sum2, cry2;

    generate
        if (USE_CSA != 0 && FF_CSA != 0) begin : g_red
            logic            v_q;
            logic [TAGW-1:0] t_q;
            logic [W-1:0]    s_q, c_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    v_q <= 1'b0;
                    t_q <= '0;
                    s_q <= '0;
                    c_q <= '0;
                end else if (en) begin
                    v_q <= v1;
                    t_q <= t1;
                    s_q <= sum_d;
                    c_q <= cry_d;
                end
            end
            assign v2   = v_q;
            assign t2   = t_q;
            assign sum2 = s_q;
            assign cry2 = c_q;
        end else begin : g_red_c
            assign v2   = v1;
            assign t2   = t1;
            assign sum2 = sum_d;
            assign cry2 = cry_d;
        end
    endgenerate

    logic [W-1:0] c_d;
    assign c_d = sum2 + cry2;

    generate
        if (FF_OUT != 0) begin : g_out
            logic            v_q;
            logic [TAGW-1:0] t_q;
            logic [W-1:0]    c_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    v_q <= 1'b0;
                    t_q <= '0;
                    c_q <= '0;
                end else if (en) begin
                    v_q <= v2;
                    t_q <= t2;
                    c_q <= c_d;
                end
            end
            assign out_valid = v_q;
            assign out_tag   = t_q;
            assign C         = c_q;
        end else begin : g_out_c
            assign out_valid = v2;
            assign out_tag   = t2;
            assign C         = c_d;
        end
    endgenerate
endmodule

// File: tb/tb_intmul_pipe_nxm.sv
// Bench for intmul_pipe_nxm: several configurations share one stimulus
// stream; each is checked against an arithmetic model with a timed queue.
module tb_intmul_pipe_nxm;
    localparam int NI = 12;
    localparam int PLA [NI] = '{60, 17, 64, 60, 64, 17, 60, 64, 17, 64, 60, 128};
    localparam int PLB [NI] = '{60, 17, 33, 60, 33, 17, 60, 33, 17, 33, 60, 2};
    localparam int PFI [NI] = '{1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 1, 0};
    localparam int PFM [NI] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 1};
    localparam int PFC [NI] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    localparam int PFO [NI] = '{1, 0, 1, 0, 1, 1, 1, 0, 1, 1, 0, 0};
    localparam int PCS [NI] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1};
    localparam int PSM [NI] = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0};

    typedef struct {
        int           e;
        logic [3:0]   t;
        logic [255:0] c;
    } exp_t;

    logic         clk;
    logic         rst, en, vin, sg;
    logic [3:0]   tg;
    logic [127:0] a_s, b_s;
    logic         chk_on, post_rst;
    int           nvec = 0;
    int           nerr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [255:0] got,
                       input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", t, got, exp);
        end
    endtask

    function automatic logic [255:0] ref_mul(input logic [127:0] a,
                                             input logic [127:0] b,
                                             input logic s,
                                             input int la, input int lb);
        logic [255:0] xa, xb, p, m;
        xa = '0;
        xb = '0;
        m  = '0;
        for (int i = 0; i < 256; i++) begin
            xa[i] = (i < la) ? a[i] : (s & a[la-1]);
            xb[i] = (i < lb) ? b[i] : (s & b[lb-1]);
            if (i < la + lb) m[i] = 1'b1;
        end
        p = xa * xb;
        return p & m;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LA = PLA[g];
        localparam int LB = PLB[g];
        localparam int LT = PFI[g] + PFM[g] + ((PCS[g] != 0) ? PFC[g] : 0) + PFO[g];
        logic             ov;
        logic [3:0]       ot;
        logic [LA+LB-1:0] c;

        intmul_pipe_nxm #(
            .LOGA(LA), .LOGB(LB), .TAGW(4),
            .FF_IN(PFI[g]), .FF_MUL(PFM[g]), .USE_CSA(PCS[g]),
            .FF_CSA(PFC[g]), .FF_OUT(PFO[g]), .SMLL_DSP(PSM[g])
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .in_valid(vin), .sgn(sg),
            .tag(tg), .A(a_s[LA-1:0]), .B(b_s[LB-1:0]),
            .out_valid(ov), .out_tag(ot), .C(c)
        );

        if (LT == 0) begin : g_comb
            always @(negedge clk) begin
                if (chk_on) begin
                    chk($sformatf("i%0d_v", g), 256'(ov), 256'(vin));
                    if (vin) begin
                        chk($sformatf("i%0d_tag", g), 256'(ot), 256'(tg));
                        chk($sformatf("i%0d_c", g), 256'(c),
                            ref_mul(a_s, b_s, sg, LA, LB));
                    end
                end
            end
        end else begin : g_seq
            exp_t q[$];
            int   ec = 0;
            always @(posedge clk) begin
                if (!rst) begin
                    q.delete();
                end else if (en) begin
                    if (vin) q.push_back('{ec + 1, tg, ref_mul(a_s, b_s, sg, LA, LB)});
                    ec <= ec + 1;
                end
            end
            always @(negedge clk) begin
                if (chk_on) begin
                    if (q.size() > 0 && q[0].e + LT - 1 < ec) void'(q.pop_front());
                    if (q.size() > 0 && q[0].e + LT - 1 == ec) begin
                        chk($sformatf("i%0d_v", g), 256'(ov), 256'(1'b1));
                        chk($sformatf("i%0d_tag", g), 256'(ot), 256'(q[0].t));
                        chk($sformatf("i%0d_c", g), 256'(c), q[0].c);
                    end else begin
                        chk($sformatf("i%0d_bubble", g), 256'(ov), 256'(1'b0));
                    end
                    if (post_rst) begin
                        chk($sformatf("i%0d_rst_c", g), 256'(c), 256'(0));
                        chk($sformatf("i%0d_rst_tag", g), 256'(ot), 256'(0));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [3:0] t,
                         input logic [127:0] a, input logic [127:0] b);
        vin = v;
        sg  = s;
        tg  = t;
        a_s = a;
        b_s = b;
    endtask

    function automatic logic [127:0] rnd_op();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 5))
            0: r = '1;
            1: r = '0;
            2: r = 128'(1) << $urandom_range(0, 127);
            3: r = ~(128'(1) << $urandom_range(0, 127));
            default: ;
        endcase
        return r;
    endfunction

    logic [127:0] ones60;
    assign ones60 = {68'd0, {60{1'b1}}};

    initial begin
        rst = 1'b0; en = 1'b1; chk_on = 1'b0; post_rst = 1'b0;
        drive(1'b0, 1'b0, 4'd0, '0, '0);
        step();
        step();
        chk_on = 1'b1;
        post_rst = 1'b1;
        rst = 1'b1;
        step();
        post_rst = 1'b0;

        drive(1'b1, 1'b0, 4'd1, ones60, ones60);
        step();
        drive(1'b1, 1'b0, 4'd2, '0, '0);
        step();
        drive(1'b0, 1'b0, 4'd0, '0, '0);
        step();
        step();
        chk("max_c", 256'(g_dut[0].c), 256'(120'hFFFFFFFFFFFFFFE000000000000001));
        chk("max_v", 256'(g_dut[0].ov), 256'(1'b1));
        step();
        chk("zero_c", 256'(g_dut[0].c), 256'(0));

        drive(1'b1, 1'b1, 4'd3, ones60, 128'd2);
        step();
        drive(1'b1, 1'b1, 4'd4, ones60, ones60);
        step();
        drive(1'b1, 1'b0, 4'd5, ones60, ones60);
        step();
        drive(1'b0, 1'b0, 4'd0, '0, '0);
        step();
        chk("m1x2_c", 256'(g_dut[0].c), 256'(120'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFE));
        step();
        chk("m1xm1_c", 256'(g_dut[0].c), 256'(1));
        step();
        chk("umax_c", 256'(g_dut[0].c), 256'(120'hFFFFFFFFFFFFFFE000000000000001));
        chk("umax_tag", 256'(g_dut[0].ot), 256'(5));

        for (int t = 0; t < 16; t++) begin
            drive(1'b1, 1'($urandom), 4'(t), rnd_op(), rnd_op());
            step();
        end
        drive(1'b0, 1'b0, 4'd0, '0, '0);
        repeat (8) step();

        drive(1'b1, 1'b0, 4'd1, rnd_op(), rnd_op());
        step();
        drive(1'b0, 1'b0, 4'd0, '0, '0);
        step();
        drive(1'b1, 1'b1, 4'd2, rnd_op(), rnd_op());
        step();
        drive(1'b1, 1'b1, 4'd3, rnd_op(), rnd_op());
        step();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'($urandom), 4'(9 + k), rnd_op(), rnd_op());
            step();
        end
        en = 1'b1;
        drive(1'b1, 1'b0, 4'd4, rnd_op(), rnd_op());
        step();
        drive(1'b0, 1'b0, 4'd0, '0, '0);
        repeat (8) step();

        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'($urandom), 4'(k + 6), rnd_op(), rnd_op());
            step();
        end
        drive(1'b0, 1'b0, 4'd0, '0, '0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        post_rst = 1'b1;
        step();
        post_rst = 1'b0;
        repeat (10) step();

        for (int n = 0; n < 1300; n++) begin
            en = ($urandom_range(0, 9) != 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                  rnd_op(), rnd_op());
            step();
        end
        en = 1'b1;
        drive(1'b0, 1'b0, 4'd0, '0, '0);
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
